// File: rtl/alu_op_sequencer_if.sv
// Command and result channels between the UART/LED front end (master) and
// the ALU op sequencer (slave).
interface alu_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_unit;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_size;
  logic [1:0]  cmd_ra;
  logic [1:0]  cmd_rb;
  logic [1:0]  cmd_rd;
  logic [1:0]  cmd_rmode;
  logic [63:0] cmd_imm;

  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        res_sign;
  logic        res_err;

  modport master (
    output cmd_valid, cmd_unit, cmd_op, cmd_size, cmd_ra, cmd_rb, cmd_rd,
           cmd_rmode, cmd_imm, res_ready,
    input  cmd_ready, res_valid, res_data, res_sign, res_err
  );

  modport slave (
    input  cmd_valid, cmd_unit, cmd_op, cmd_size, cmd_ra, cmd_rb, cmd_rd,
           cmd_rmode, cmd_imm, res_ready,
    output cmd_ready, res_valid, res_data, res_sign, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// One-command-at-a-time controller for the shared FPU / integer datapath with a
// 4 x 64-bit register file and a valid/ready result port.
module alu_op_sequencer #(
  parameter int unsigned INT_LAT     = 2,
  parameter int unsigned FPU_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [63:0]         fu_opa,
  output logic [63:0]         fu_opb,
  output logic [2:0]          fu_op,
  output logic [1:0]          fu_rmode,
  input  logic [63:0]         fp_out,
  input  logic                fp_ready,
  input  logic [63:0]         calc_out,
  input  logic [63:0]         manip_out,
  input  logic [63:0]         logic_out,
  output logic                busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_OUT} state_e;

  localparam logic [2:0] U_FPU   = 3'd0;
  localparam logic [2:0] U_CALC  = 3'd1;
  localparam logic [2:0] U_MANIP = 3'd2;
  localparam logic [2:0] U_LOGIC = 3'd3;
  localparam logic [2:0] U_FETCH = 3'd4;
  localparam logic [2:0] U_STORE = 3'd5;

  localparam logic [7:0] INT_LAST = 8'(INT_LAT - 1);
  localparam logic [7:0] FPU_LAST = 8'(FPU_TIMEOUT - 1);

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd1:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
  endfunction

  function automatic logic size_msb(input logic [63:0] r, input logic [1:0] size);
    case (size)
      2'd0:    size_msb = r[15];
      2'd1:    size_msb = r[31];
      default: size_msb = r[63];
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  unit_q, unit_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  ra_q, ra_d;
  logic [1:0]  rd_q, rd_d;
  logic [63:0] imm_q, imm_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] capt_q, capt_d;
  logic        err_q, err_d;
  logic [63:0] fu_opa_q, fu_opa_d;
  logic [63:0] fu_opb_q, fu_opb_d;
  logic [2:0]  fu_op_q, fu_op_d;
  logic [1:0]  fu_rmode_q, fu_rmode_d;
  logic [63:0] res_data_q, res_data_d;
  logic        res_sign_q, res_sign_d;
  logic        res_err_q, res_err_d;
  logic [63:0] regs_q [4];
  logic [63:0] regs_d [4];
  logic [63:0] wb_res;

  // Write-back value; errors force zero, everything is clipped to the command size.
  always_comb begin
    wb_res = '0;
    if (!err_q) begin
      case (unit_q)
        U_FETCH: wb_res = regs_q[ra_q];
        U_STORE: wb_res = imm_q;
        default: wb_res = capt_q;
      endcase
    end
    wb_res = wb_res & size_mask(size_q);
  end

  // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    unit_d     = unit_q;
    size_d     = size_q;
    ra_d       = ra_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    cnt_d      = cnt_q;
    capt_d     = capt_q;
    err_d      = err_q;
    fu_opa_d   = fu_opa_q;
    fu_opb_d   = fu_opb_q;
    fu_op_d    = fu_op_q;
    fu_rmode_d = fu_rmode_q;
    res_data_d = res_data_q;
    res_sign_d = res_sign_q;
    res_err_d  = res_err_q;
    regs_d     = regs_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          // Operands are sampled here so they are already on the bus during ISSUE.
          unit_d     = bus.cmd_unit;
          size_d     = bus.cmd_size;
          ra_d       = bus.cmd_ra;
          rd_d       = bus.cmd_rd;
          imm_d      = bus.cmd_imm;
          fu_opa_d   = regs_q[bus.cmd_ra] & size_mask(bus.cmd_size);
          fu_opb_d   = regs_q[bus.cmd_rb] & size_mask(bus.cmd_size);
          fu_op_d    = bus.cmd_op;
          fu_rmode_d = bus.cmd_rmode;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (unit_q <= U_LOGIC) begin
          state_d = S_WAIT;
        end else if (unit_q <= U_STORE) begin
          state_d = S_WB;
        end else begin
          err_d   = 1'b1;
          state_d = S_WB;
        end
      end
      S_WAIT: begin
        if (unit_q == U_FPU) begin
          if (fp_ready) begin
            capt_d  = fp_out;
            state_d = S_WB;
          end else if (cnt_q == FPU_LAST) begin
            err_d   = 1'b1;
            state_d = S_WB;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (cnt_q == INT_LAST) begin
          case (unit_q)
            U_CALC:  capt_d = calc_out;
            U_MANIP: capt_d = manip_out;
            default: capt_d = logic_out;
          endcase
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        if (!err_q && unit_q != U_FETCH) regs_d[rd_q] = wb_res;
        res_data_d = wb_res;
        res_sign_d = size_msb(wb_res, size_q);
        res_err_d  = err_q;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the register file is cleared on reset because a fetch after reset must read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      unit_q     <= '0;
      size_q     <= '0;
      ra_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      cnt_q      <= '0;
      capt_q     <= '0;
      err_q      <= 1'b0;
      fu_opa_q   <= '0;
      fu_opb_q   <= '0;
      fu_op_q    <= '0;
      fu_rmode_q <= '0;
      res_data_q <= '0;
      res_sign_q <= 1'b0;
      res_err_q  <= 1'b0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      unit_q     <= unit_d;
      size_q     <= size_d;
      ra_q       <= ra_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      cnt_q      <= cnt_d;
      capt_q     <= capt_d;
      err_q      <= err_d;
      fu_opa_q   <= fu_opa_d;
      fu_opb_q   <= fu_opb_d;
      fu_op_q    <= fu_op_d;
      fu_rmode_q <= fu_rmode_d;
      res_data_q <= res_data_d;
      res_sign_q <= res_sign_d;
      res_err_q  <= res_err_d;
      regs_q     <= regs_d;
    end
  end

  assign fu_opa        = fu_opa_q;
  assign fu_opb        = fu_opb_q;
  assign fu_op         = fu_op_q;
  assign fu_rmode      = fu_rmode_q;
  assign busy          = (state_q != S_IDLE);
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.res_valid = (state_q == S_OUT);
  assign bus.res_data  = res_data_q;
  assign bus.res_sign  = res_sign_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: directed scenarios plus random commands against a
// command-level reference model of the register file and result latency.
module tb_alu_op_sequencer;

  localparam int INT_LAT     = 2;
  localparam int FPU_TIMEOUT = 64;
  localparam int NEVER       = 1000;

  typedef struct {
    logic [2:0]  unit;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [1:0]  rd;
    logic [1:0]  rmode;
    logic [63:0] imm;
    logic [63:0] fp_val;
    int          fp_k;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] fu_opa, fu_opb, fp_out, calc_out, manip_out, logic_out;
  logic [2:0]  fu_op;
  logic [1:0]  fu_rmode;
  logic        fp_ready, busy;

  always #5 clk = ~clk;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.INT_LAT(INT_LAT), .FPU_TIMEOUT(FPU_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fu_opa    (fu_opa),
    .fu_opb    (fu_opb),
    .fu_op     (fu_op),
    .fu_rmode  (fu_rmode),
    .fp_out    (fp_out),
    .fp_ready  (fp_ready),
    .calc_out  (calc_out),
    .manip_out (manip_out),
    .logic_out (logic_out),
    .busy      (busy)
  );

  // Simple behavioural stand-ins for the integer units.
  function automatic logic [63:0] calc_f(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0:    calc_f = a + b;
      3'd1:    calc_f = a - b;
      3'd2:    calc_f = a * b;
      default: calc_f = a + 64'd1;
    endcase
  endfunction

  function automatic logic [63:0] manip_f(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0:    manip_f = ~a;
      3'd1:    manip_f = a << 1;
      3'd2:    manip_f = a >> 1;
      default: manip_f = {a[31:0], a[63:32]} ^ b;
    endcase
  endfunction

  function automatic logic [63:0] logic_f(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0:    logic_f = a & b;
      3'd1:    logic_f = a | b;
      3'd2:    logic_f = a ^ b;
      default: logic_f = ~(a & b);
    endcase
  endfunction

  assign calc_out  = calc_f(fu_op, fu_opa, fu_opb);
  assign manip_out = manip_f(fu_op, fu_opa, fu_opb);
  assign logic_out = logic_f(fu_op, fu_opa, fu_opb);

  function automatic logic [63:0] mask_of(input logic [1:0] size);
    if (size == 2'd0)      mask_of = 64'hFFFF;
    else if (size == 2'd1) mask_of = 64'hFFFF_FFFF;
    else                   mask_of = 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic int msb_of(input logic [1:0] size);
    msb_of = (size == 2'd0) ? 15 : (size == 2'd1) ? 31 : 63;
  endfunction

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cmd_idx = 0;
  logic [63:0] model_regs [4];
  cmd_t        none_cmd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input cmd_t c);
    bus.cmd_unit  = c.unit;
    bus.cmd_op    = c.op;
    bus.cmd_size  = c.size;
    bus.cmd_ra    = c.ra;
    bus.cmd_rb    = c.rb;
    bus.cmd_rd    = c.rd;
    bus.cmd_rmode = c.rmode;
    bus.cmd_imm   = c.imm;
    bus.cmd_valid = 1'b1;
  endtask

  function automatic cmd_t mk(input logic [2:0] unit, input logic [2:0] op, input logic [1:0] size,
                              input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                              input logic [63:0] imm, input logic [63:0] fp_val, input int fp_k);
    cmd_t c;
    c.unit = unit; c.op = op; c.size = size; c.ra = ra; c.rb = rb; c.rd = rd;
    c.rmode = op[1:0] ^ rd; c.imm = imm; c.fp_val = fp_val; c.fp_k = fp_k;
    return c;
  endfunction

  // Issue one command from IDLE, measure latency, check the result, then handshake.
  task automatic run_cmd(input cmd_t c, input int hold, input bit have_next, input cmd_t nxt);
    logic [63:0] m, opa, opb, exp_r, snap_d;
    logic        exp_err, exp_sign, snap_s, snap_e;
    int          exp_lat, lat, waitc;
    string       t;
    m = mask_of(c.size);
    opa = model_regs[c.ra] & m;
    opb = model_regs[c.rb] & m;
    exp_err = 1'b0;
    exp_r = '0;
    exp_lat = 3;
    case (c.unit)
      3'd0: begin
        if (c.fp_k < FPU_TIMEOUT) begin exp_r = c.fp_val & m; exp_lat = 4 + c.fp_k; end
        else begin exp_err = 1'b1; exp_lat = 3 + FPU_TIMEOUT; end
      end
      3'd1: begin exp_r = calc_f(c.op, opa, opb) & m;  exp_lat = 3 + INT_LAT; end
      3'd2: begin exp_r = manip_f(c.op, opa, opb) & m; exp_lat = 3 + INT_LAT; end
      3'd3: begin exp_r = logic_f(c.op, opa, opb) & m; exp_lat = 3 + INT_LAT; end
      3'd4: exp_r = opa;
      3'd5: exp_r = c.imm & m;
      default: exp_err = 1'b1;
    endcase
    exp_sign = exp_r[msb_of(c.size)];
    cmd_idx++;
    t = $sformatf("cmd%0d u%0d", cmd_idx, c.unit);

    drive_cmd(c);
    waitc = 0;
    while (bus.cmd_ready !== 1'b1 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      check({t, " accept timeout"}, 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b0;
      return;
    end

    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.res_valid === 1'b1) break;
      if (lat == 1) begin
        bus.cmd_valid = 1'b0;
        check({t, " issue busy/ready"}, {62'd0, busy, bus.cmd_ready}, 64'b10);
        check({t, " fu_opa"}, fu_opa, opa);
        check({t, " fu_opb"}, fu_opb, opb);
        check({t, " fu_op/rmode"}, {59'd0, fu_op, fu_rmode}, {59'd0, c.op, c.rmode});
      end
      // fp_ready noise where it must be ignored: ISSUE cycle, and any non-FPU command.
      if (c.unit == 3'd0 && lat == c.fp_k + 2) begin
        fp_ready = 1'b1;
        fp_out   = c.fp_val;
      end else if (lat == 1 || (c.unit != 3'd0 && $urandom_range(0, 2) == 0)) begin
        fp_ready = 1'b1;
        fp_out   = {$urandom, $urandom};
      end else begin
        fp_ready = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    fp_ready = 1'b0;

    check({t, " latency"}, 64'(lat), 64'(exp_lat));
    check({t, " res_data"}, bus.res_data, exp_r);
    check({t, " sign/err"}, {62'd0, bus.res_sign, bus.res_err}, {62'd0, exp_sign, exp_err});

    snap_d = bus.res_data;
    snap_s = bus.res_sign;
    snap_e = bus.res_err;
    for (int i = 0; i < hold; i++) begin
      if (have_next && i == 1) drive_cmd(nxt);
      @(negedge clk);
      check({t, " hold data"}, bus.res_data, snap_d);
      check({t, " hold flags"}, {60'd0, bus.res_valid, bus.cmd_ready, bus.res_sign, bus.res_err},
            {60'd0, 1'b1, 1'b0, snap_s, snap_e});
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({t, " post hs flags"}, {61'd0, bus.res_valid, bus.cmd_ready, busy}, 64'b010);
    check({t, " post hs data"}, bus.res_data, snap_d);

    if (!exp_err && c.unit != 3'd4) model_regs[c.rd] = exp_r;
  endtask

  task automatic fetch_all;
    for (int r = 0; r < 4; r++)
      run_cmd(mk(3'd4, 3'd0, 2'd3, 2'(r), 2'd0, 2'd0, 64'd0, 64'd0, 0), 0, 1'b0, none_cmd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c, n;
    none_cmd = mk(3'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 64'd0, 64'd0, 0);
    for (int r = 0; r < 4; r++) model_regs[r] = '0;
    rst = 1'b1;
    fp_ready = 1'b0;
    fp_out = '0;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    drive_cmd(none_cmd);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset flags", {59'd0, busy, bus.cmd_ready, bus.res_valid, bus.res_sign, bus.res_err}, 64'b01000);
    check("reset res_data", bus.res_data, 64'd0);
    check("reset fu_opa", fu_opa, 64'd0);
    check("reset fu_opb", fu_opb, 64'd0);
    check("reset fu_op/rmode", {59'd0, fu_op, fu_rmode}, 64'd0);
    fetch_all;

    // Store to C at 32 bits, then read it back at 64 bits.
    run_cmd(mk(3'd5, 3'd0, 2'd1, 2'd0, 2'd0, 2'd2, 64'h1234_5678_9ABC_DEF0, 64'd0, 0), 0, 1'b0, none_cmd);
    run_cmd(mk(3'd4, 3'd0, 2'd3, 2'd2, 2'd0, 2'd0, 64'd0, 64'd0, 0), 0, 1'b0, none_cmd);

    // A=5, B=7, D = A+B at 16 bits, fetch D.
    run_cmd(mk(3'd5, 3'd0, 2'd2, 2'd0, 2'd0, 2'd0, 64'd5, 64'd0, 0), 0, 1'b0, none_cmd);
    run_cmd(mk(3'd5, 3'd0, 2'd2, 2'd0, 2'd0, 2'd1, 64'd7, 64'd0, 0), 0, 1'b0, none_cmd);
    run_cmd(mk(3'd1, 3'd0, 2'd0, 2'd0, 2'd1, 2'd3, 64'd0, 64'd0, 0), 0, 1'b0, none_cmd);
    run_cmd(mk(3'd4, 3'd0, 2'd0, 2'd3, 2'd0, 2'd0, 64'd0, 64'd0, 0), 0, 1'b0, none_cmd);

    // FPU: ready after 10 WAIT cycles, timeout, and ready on the last allowed cycle.
    run_cmd(mk(3'd0, 3'd0, 2'd3, 2'd0, 2'd1, 2'd1, 64'd0, 64'h4008_0000_0000_0000, 10), 0, 1'b0, none_cmd);
    run_cmd(mk(3'd0, 3'd0, 2'd3, 2'd0, 2'd1, 2'd2, 64'd0, 64'h4008_0000_0000_0000, NEVER), 0, 1'b0, none_cmd);
    run_cmd(mk(3'd4, 3'd0, 2'd3, 2'd2, 2'd0, 2'd0, 64'd0, 64'd0, 0), 0, 1'b0, none_cmd);
    run_cmd(mk(3'd0, 3'd1, 2'd1, 2'd1, 2'd1, 2'd0, 64'd0, 64'hC000_0000_8765_4321, FPU_TIMEOUT - 1),
            0, 1'b0, none_cmd);

    // Consumer stalls 20 cycles while the next command is already waiting.
    c = mk(3'd3, 3'd2, 2'd1, 2'd0, 2'd2, 2'd3, 64'd0, 64'd0, 0);
    n = mk(3'd2, 3'd3, 2'd2, 2'd3, 2'd1, 2'd3, 64'd0, 64'd0, 0);
    run_cmd(c, 20, 1'b1, n);
    run_cmd(n, 0, 1'b0, none_cmd);

    // Reset in the middle of an int_log WAIT drops everything.
    drive_cmd(mk(3'd3, 3'd1, 2'd2, 2'd0, 2'd1, 2'd0, 64'd0, 64'd0, 0));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("mid-op busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst abort flags", {61'd0, busy, bus.cmd_ready, bus.res_valid}, 64'b010);
    check("rst abort res_data", bus.res_data, 64'd0);
    check("rst abort fu_opa", fu_opa, 64'd0);
    for (int r = 0; r < 4; r++) model_regs[r] = '0;
    fetch_all;

    // Illegal unit: error result, no register write.
    run_cmd(mk(3'd5, 3'd0, 2'd2, 2'd0, 2'd0, 2'd0, 64'hDEAD_BEEF_0000_8001, 64'd0, 0), 0, 1'b0, none_cmd);
    run_cmd(mk(3'd6, 3'd0, 2'd2, 2'd0, 2'd0, 2'd0, 64'hFFFF, 64'd0, 0), 0, 1'b0, none_cmd);
    run_cmd(mk(3'd7, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0, 64'hFFFF, 64'd0, 0), 1, 1'b0, none_cmd);
    run_cmd(mk(3'd4, 3'd0, 2'd2, 2'd0, 2'd0, 2'd0, 64'd0, 64'd0, 0), 0, 1'b0, none_cmd);

    // Random mix of all units, sizes, register hazards and consumer stalls.
    for (int i = 0; i < 40; i++) begin
      c = mk(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             {$urandom, $urandom}, {$urandom, $urandom},
             ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 12)));
      run_cmd(c, int'($urandom_range(0, 3)), 1'b0, none_cmd);
    end
    fetch_all;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
